// File: rtl/minhash_bottomk_sorter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minhash_bottomk_sorter_pkg                                                 |
// | Shared types and defaults for the bottom-k MinHash sketch sorter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package minhash_bottomk_sorter_pkg;

    localparam int unsigned HASHER_SORTER_SIGNATURE = 32;
    localparam int unsigned SORTER_INDICE_LEN       = 8;
    localparam int unsigned SORTER_DEPTH            = 8;
    localparam bit          SORTER_DEDUP            = 1'b1;

    typedef struct packed {
        logic [HASHER_SORTER_SIGNATURE-1:0] signature;
        logic [SORTER_INDICE_LEN-1:0]       indice;
    } signature_index_pack;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_DRAIN   = 1'b1
    } sorter_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD        = 2'd0,
        SEL_LOAD_IN     = 2'd1,
        SEL_LOAD_LEFT   = 2'd2,
        SEL_SHIFT_RIGHT = 2'd3
    } slot_sel_e;

endpackage
`default_nettype wire

// File: rtl/minhash_bottomk_sorter_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minhash_sort_slot                                                          |
// | One sketch slot: holds a (signature, index) pair and compares the input.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module minhash_sort_slot
    import minhash_bottomk_sorter_pkg::*;
#(
    parameter int unsigned SIG_W = HASHER_SORTER_SIGNATURE,
    parameter int unsigned IDX_W = SORTER_INDICE_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  slot_sel_e        sel,
    input  logic [SIG_W-1:0] in_sig,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             left_valid,
    input  logic [SIG_W-1:0] left_sig,
    input  logic [IDX_W-1:0] left_idx,
    input  logic             right_valid,
    input  logic [SIG_W-1:0] right_sig,
    input  logic [IDX_W-1:0] right_idx,
    output logic             valid,
    output logic [SIG_W-1:0] sig,
    output logic [IDX_W-1:0] idx,
    output logic             lt,
    output logic             eq
);

    logic             r_valid;
    logic [SIG_W-1:0] r_sig;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sig   <= '0;
            r_idx   <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_sig   <= '0;
            r_idx   <= '0;
        end else begin
            case (sel)
                SEL_LOAD_IN: begin
                    r_valid <= 1'b1;
                    r_sig   <= in_sig;
                    r_idx   <= in_idx;
                end
                SEL_LOAD_LEFT: begin
                    r_valid <= left_valid;
                    r_sig   <= left_sig;
                    r_idx   <= left_idx;
                end
                SEL_SHIFT_RIGHT: begin
                    r_valid <= right_valid;
                    r_sig   <= right_sig;
                    r_idx   <= right_idx;
                end
                default: begin
                    r_valid <= r_valid;
                    r_sig   <= r_sig;
                    r_idx   <= r_idx;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign sig   = r_sig;
    assign idx   = r_idx;
    // An empty slot sorts after everything, so lt marks "input belongs at or before here".
    assign lt    = ~r_valid | (in_sig < r_sig);
    assign eq    = r_valid & (in_sig == r_sig);

endmodule
`default_nettype wire

// File: rtl/minhash_bottomk_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minhash_bottomk_sorter                                                     |
// | Streaming bottom-k sketch: keeps the DEPTH smallest pairs, drains sorted.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module minhash_bottomk_sorter
    import minhash_bottomk_sorter_pkg::*;
#(
    parameter int unsigned SIG_W = HASHER_SORTER_SIGNATURE,
    parameter int unsigned IDX_W = SORTER_INDICE_LEN,
    parameter int unsigned DEPTH = SORTER_DEPTH,
    parameter bit          DEDUP = SORTER_DEDUP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIG_W-1:0]           in_sig,
    input  logic [IDX_W-1:0]           in_idx,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIG_W-1:0]           out_sig,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    sorter_state_e    r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_count, w_count_nxt;

    logic [DEPTH-1:0] w_valid, w_lt, w_eq, w_pos;
    logic [SIG_W-1:0] w_sig [DEPTH];
    logic [IDX_W-1:0] w_idx [DEPTH];
    slot_sel_e        w_sel [DEPTH];

    logic [DEPTH-1:0] w_left_valid, w_right_valid;
    logic [SIG_W-1:0] w_left_sig [DEPTH];
    logic [SIG_W-1:0] w_right_sig [DEPTH];
    logic [IDX_W-1:0] w_left_idx [DEPTH];
    logic [IDX_W-1:0] w_right_idx [DEPTH];

    logic w_accept, w_pop, w_insert, w_dup, w_any_lt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        minhash_sort_slot #(
            .SIG_W (SIG_W),
            .IDX_W (IDX_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .sel         (w_sel[i]),
            .in_sig      (in_sig),
            .in_idx      (in_idx),
            .left_valid  (w_left_valid[i]),
            .left_sig    (w_left_sig[i]),
            .left_idx    (w_left_idx[i]),
            .right_valid (w_right_valid[i]),
            .right_sig   (w_right_sig[i]),
            .right_idx   (w_right_idx[i]),
            .valid       (w_valid[i]),
            .sig         (w_sig[i]),
            .idx         (w_idx[i]),
            .lt          (w_lt[i]),
            .eq          (w_eq[i])
        );
    end

    // Neighbour wiring; the chain ends feed in an empty (all-zero) slot.
    always_comb begin
        w_left_valid  = '0;
        w_right_valid = '0;
        w_left_sig    = '{default: '0};
        w_right_sig   = '{default: '0};
        w_left_idx    = '{default: '0};
        w_right_idx   = '{default: '0};
        for (int i = 1; i < DEPTH; i++) begin
            w_left_valid[i] = w_valid[i-1];
            w_left_sig[i]   = w_sig[i-1];
            w_left_idx[i]   = w_idx[i-1];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_right_valid[i] = w_valid[i+1];
            w_right_sig[i]   = w_sig[i+1];
            w_right_idx[i]   = w_idx[i+1];
        end
    end

    // lt is a thermometer (0..0 1..1) over sorted slots, so its rising edge is the insert point.
    assign w_pos    = w_lt & ~(w_lt << 1);
    assign w_any_lt = |w_lt;
    assign w_dup    = |w_eq;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        in_ready    = (r_state == S_COLLECT);
        out_valid   = (r_state == S_DRAIN);
        w_accept    = in_valid & in_ready & ~clear;
        w_pop       = out_valid & out_ready & ~clear;
        w_insert    = w_accept & w_any_lt & ~(DEDUP & w_dup);
        if (clear) begin
            w_state_nxt = S_COLLECT;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_insert && !w_valid[DEPTH-1]) begin
                        w_count_nxt = r_count + c_cnt_w'(1);
                    end
                    if (w_accept && in_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        w_count_nxt = r_count - c_cnt_w'(1);
                        if (r_count == c_cnt_w'(1)) begin
                            w_state_nxt = S_COLLECT;
                        end
                    end
                end
                default: w_state_nxt = S_COLLECT;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = SEL_HOLD;
            if (w_pop) begin
                w_sel[i] = SEL_SHIFT_RIGHT;
            end else if (w_insert) begin
                if (w_pos[i]) begin
                    w_sel[i] = SEL_LOAD_IN;
                end else if (w_lt[i]) begin
                    w_sel[i] = SEL_LOAD_LEFT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign count    = r_count;
    assign out_sig  = out_valid ? w_sig[0] : '0;
    assign out_idx  = out_valid ? w_idx[0] : '0;
    assign out_last = out_valid & (r_count == c_cnt_w'(1));

endmodule
`default_nettype wire

// File: tb/tb_minhash_bottomk_sorter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_minhash_bottomk_sorter                                                  |
// | Scoreboard bench: DEPTH=4 with DEDUP=1 (dut) and DEDUP=0 (dut0).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_minhash_bottomk_sorter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] sig;
        logic [7:0]  idx;
        logic        last;
    } pair_t;
    typedef pair_t pq_t[$];

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_valid0, in_last, out_ready, out_ready0;
    logic [31:0] in_sig;
    logic [7:0]  in_idx;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_sig;
    logic [7:0]  out_idx;
    logic [2:0]  count;
    logic        in_ready0, out_valid0, out_last0;
    logic [31:0] out_sig0;
    logic [7:0]  out_idx0;
    logic [2:0]  count0;

    pq_t exp_q, exp_q0, mdl, mdl0;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    minhash_bottomk_sorter #(.SIG_W(32), .IDX_W(8), .DEPTH(DEPTH), .DEDUP(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig), .in_idx(in_idx),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sig(out_sig), .out_idx(out_idx), .out_last(out_last), .count(count)
    );

    minhash_bottomk_sorter #(.SIG_W(32), .IDX_W(8), .DEPTH(DEPTH), .DEDUP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_sig(in_sig), .in_idx(in_idx),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_sig(out_sig0), .out_idx(out_idx0), .out_last(out_last0), .count(count0)
    );

    // Reference bottom-k: sorted list, stable ties, drop when full and not smaller than max.
    function automatic pq_t model_ins(input pq_t q, input logic [31:0] s,
                                      input logic [7:0] x, input bit dedup);
        pq_t   r;
        int    pos;
        pair_t p;
        r = q;
        if (dedup) begin
            foreach (r[i]) if (r[i].sig == s) return r;
        end
        pos = r.size();
        for (int i = 0; i < r.size(); i++) begin
            if (s < r[i].sig) begin
                pos = i;
                break;
            end
        end
        if (pos >= DEPTH) return r;
        p.sig  = s;
        p.idx  = x;
        p.last = 1'b0;
        r.insert(pos, p);
        if (r.size() > DEPTH) void'(r.pop_back());
        return r;
    endfunction

    task automatic send(input logic [31:0] s, input logic [7:0] x, input bit last, input bit both);
        in_valid  = 1'b1;
        in_valid0 = both;
        in_sig    = s;
        in_idx    = x;
        in_last   = last;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL send_in_ready sig=%0d got=%b want=1", s, in_ready);
        if (in_ready !== 1'b1) errors++;
        mdl = model_ins(mdl, s, x, 1'b1);
        if (both) mdl0 = model_ins(mdl0, s, x, 1'b0);
        if (last) begin
            mdl[mdl.size()-1].last = 1'b1;
            foreach (mdl[i]) exp_q.push_back(mdl[i]);
            mdl.delete();
            if (both) begin
                mdl0[mdl0.size()-1].last = 1'b1;
                foreach (mdl0[i]) exp_q0.push_back(mdl0[i]);
                mdl0.delete();
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic drain(input bit which, input bit toggle, input int npops);
        int          pops = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        logic        v, l, ir, rdy;
        logic [31:0] s;
        logic [7:0]  x;
        logic [2:0]  c;
        pair_t       e;
        while (pops < npops && (which ? exp_q0.size() : exp_q.size()) > 0) begin
            if (cyc >= 200) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout which=%0d pops=%0d", which, pops);
                break;
            end
            v  = which ? out_valid0 : out_valid;
            s  = which ? out_sig0   : out_sig;
            x  = which ? out_idx0   : out_idx;
            l  = which ? out_last0  : out_last;
            c  = which ? count0     : count;
            ir = which ? in_ready0  : in_ready;
            e  = which ? exp_q0[0]  : exp_q[0];
            checks++;
            if (v !== 1'b1 || s !== e.sig || x !== e.idx || l !== e.last) begin
                errors++;
                $display("FAIL drain_pair which=%0d got v=%b sig=%0d idx=%0d last=%b want sig=%0d idx=%0d last=%b",
                         which, v, s, x, l, e.sig, e.idx, e.last);
            end
            checks++;
            if (c !== 3'((which ? exp_q0.size() : exp_q.size()))) begin
                errors++;
                $display("FAIL drain_count which=%0d got=%0d want=%0d", which, c,
                         (which ? exp_q0.size() : exp_q.size()));
            end
            checks++;
            if (ir !== 1'b0) begin
                errors++;
                $display("FAIL drain_in_ready which=%0d got=%b want=0", which, ir);
            end
            if (stalled) begin
                checks++;
                if (s !== held) begin
                    errors++;
                    $display("FAIL stall_stable which=%0d got=%0d want=%0d", which, s, held);
                end
            end
            rdy = toggle ? cyc[0] : 1'b1;
            if (which) out_ready0 = rdy; else out_ready = rdy;
            if (v === 1'b1 && rdy) begin
                pops++;
                if (which) void'(exp_q0.pop_front()); else void'(exp_q.pop_front());
            end
            stalled = (v === 1'b1) && !rdy;
            held    = s;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready  = 1'b0;
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0; in_last = 1'b0;
        in_sig = '0; in_idx = '0; out_ready = 1'b0; out_ready0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_sig !== 32'd0 || out_idx !== 8'd0 ||
            out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d ov=%b sig=%0d idx=%0d last=%b ir=%b want 0 0 0 0 0 1",
                     count, out_valid, out_sig, out_idx, out_last, in_ready);
        end
    endtask

    task automatic check_idle(input bit which, input string name);
        logic       v, ir;
        logic [2:0] c;
        v  = which ? out_valid0 : out_valid;
        ir = which ? in_ready0  : in_ready;
        c  = which ? count0     : count;
        checks++;
        if (v !== 1'b0 || ir !== 1'b1 || c !== 3'd0) begin
            errors++;
            $display("FAIL %s_idle got ov=%b ir=%b cnt=%0d want ov=0 ir=1 cnt=0", name, v, ir, c);
        end
    endtask

    task automatic test_ascending();
        send(10, 1, 0, 0); send(20, 2, 0, 0); send(30, 3, 0, 0); send(40, 4, 1, 0);
        drain(0, 0, 99);
        check_idle(0, "ascending");
    endtask

    task automatic test_eviction();
        send(50, 1, 0, 0); send(40, 2, 0, 0); send(30, 3, 0, 0); send(20, 4, 0, 0);
        send(10, 5, 0, 0); send(60, 6, 0, 0); send(5, 7, 1, 0);
        drain(0, 0, 99);
        check_idle(0, "eviction");
    endtask

    task automatic test_dedup();
        send(7, 1, 0, 1); send(7, 2, 0, 1); send(3, 3, 0, 1); send(7, 4, 1, 1);
        drain(0, 0, 99);
        check_idle(0, "dedup1");
        drain(1, 0, 99);
        check_idle(1, "dedup0");
    endtask

    task automatic test_backpressure();
        send(25, 1, 0, 0); send(15, 2, 0, 0); send(35, 3, 0, 0); send(5, 4, 1, 0);
        drain(0, 1, 99);
        check_idle(0, "backpressure");
    endtask

    task automatic test_single();
        send(99, 9, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sig !== 32'd99 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got ov=%b sig=%0d last=%b want 1 99 1",
                     out_valid, out_sig, out_last);
        end
        drain(0, 0, 99);
        check_idle(0, "single");
    endtask

    task automatic test_clear();
        send(40, 1, 0, 0); send(10, 2, 0, 0); send(30, 3, 0, 0); send(20, 4, 1, 0);
        drain(0, 0, 2);
        clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        check_idle(0, "clear");
        send(3, 1, 0, 0); send(1, 2, 0, 0); send(2, 3, 1, 0);
        drain(0, 0, 99);
        check_idle(0, "after_clear");
    endtask

    task automatic test_reset_mid();
        send(8, 1, 0, 0); send(6, 2, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_count got=%0d want=0", count);
        end
        #2 rst = 1'b0;
        mdl.delete();
        @(posedge clk); #1;
        check_idle(0, "reset_mid");
        send(8, 3, 0, 0); send(6, 4, 1, 0);
        drain(0, 0, 99);
        check_idle(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_eviction();
        test_dedup();
        test_backpressure();
        test_single();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
